// File: rtl/pcap_framer.sv
// pcap_framer: turns packet words from the read FIFO into pcap records on a
// 32-bit Avalon-ST source. Each record is a 4-beat record header (sec, usec,
// incl_len, orig_len) followed by ceil(len/4) payload words. The block also
// owns the free-running sec/usec timestamp.
// Optional build macro PCAP_GLOBAL_HDR_EN: the first record after reset is
// preceded by the 6-beat pcap global header.
module pcap_framer #(
    parameter int unsigned CLK_MHZ = 50,
    parameter int unsigned LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             busy,
    output logic             done,
    input  logic [31:0]      fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    output logic [31:0]      st_data,
    output logic             st_valid,
    input  logic             st_ready,
    output logic             st_sop,
    output logic             st_eop,
    output logic [1:0]       st_empty
);

    localparam int unsigned TickW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(CLK_MHZ - 1);
    localparam logic [19:0] UsecMax = 20'd999_999;

    typedef enum logic [1:0] {
        StIdle,
`ifdef PCAP_GLOBAL_HDR_EN
        StGhdr,
`endif
        StHdr,
        StPayload
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [19:0]      usec_q, usec_d;
    logic [31:0]      sec_q, sec_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      ts_sec_q, ts_sec_d;
    logic [19:0]      ts_usec_q, ts_usec_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [1:0]       hdr_idx_q, hdr_idx_d;
    logic             done_q, done_d;
    logic [LEN_W:0]   words;
    logic             acc;
`ifdef PCAP_GLOBAL_HDR_EN
    logic [2:0]       gidx_q, gidx_d;
    logic             gh_done_q, gh_done_d;
    // Current record carries the global header, so its own header has no SOP
    logic             gh_rec_q, gh_rec_d;
`endif

    // Word count is computed one bit wider so len near 2^LEN_W does not overflow
    assign words = ({1'b0, pkt_len} + (LEN_W + 1)'(3)) >> 2;
    assign acc   = st_valid & st_ready;

    // Free-running timestamp: clk ticks -> microseconds -> seconds
    always_comb begin
        tick_d = tick_q + 1'b1;
        usec_d = usec_q;
        sec_d  = sec_q;
        if (tick_q == TickMax) begin
            tick_d = '0;
            if (usec_q == UsecMax) begin
                usec_d = '0;
                sec_d  = sec_q + 32'd1;
            end else begin
                usec_d = usec_q + 20'd1;
            end
        end
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            usec_q    <= '0;
            sec_q     <= '0;
            len_q     <= '0;
            ts_sec_q  <= '0;
            ts_usec_q <= '0;
            cnt_q     <= '0;
            hdr_idx_q <= '0;
            done_q    <= 1'b0;
`ifdef PCAP_GLOBAL_HDR_EN
            gidx_q    <= '0;
            gh_done_q <= 1'b0;
            gh_rec_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            usec_q    <= usec_d;
            sec_q     <= sec_d;
            len_q     <= len_d;
            ts_sec_q  <= ts_sec_d;
            ts_usec_q <= ts_usec_d;
            cnt_q     <= cnt_d;
            hdr_idx_q <= hdr_idx_d;
            done_q    <= done_d;
`ifdef PCAP_GLOBAL_HDR_EN
            gidx_q    <= gidx_d;
            gh_done_q <= gh_done_d;
            gh_rec_q  <= gh_rec_d;
`endif
        end
    end

    // Next-state logic: advance only on accepted beats
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ts_sec_d  = ts_sec_q;
        ts_usec_d = ts_usec_q;
        cnt_d     = cnt_q;
        hdr_idx_d = hdr_idx_q;
        done_d    = 1'b0;
`ifdef PCAP_GLOBAL_HDR_EN
        gidx_d    = gidx_q;
        gh_done_d = gh_done_q;
        gh_rec_d  = gh_rec_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d     = pkt_len;
                    ts_sec_d  = sec_q;
                    ts_usec_d = usec_q;
                    cnt_d     = words;
                    hdr_idx_d = '0;
`ifdef PCAP_GLOBAL_HDR_EN
                    gidx_d    = '0;
                    gh_rec_d  = !gh_done_q;
                    state_d   = gh_done_q ? StHdr : StGhdr;
`else
                    state_d   = StHdr;
`endif
                end
            end
`ifdef PCAP_GLOBAL_HDR_EN
            StGhdr: begin
                if (acc) begin
                    if (gidx_q == 3'd5) begin
                        gh_done_d = 1'b1;
                        state_d   = StHdr;
                    end else begin
                        gidx_d = gidx_q + 3'd1;
                    end
                end
            end
`endif
            StHdr: begin
                if (acc) begin
                    if (hdr_idx_q == 2'd3) begin
                        if (cnt_q == '0) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StPayload;
                        end
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            StPayload: begin
                if (acc) begin
                    cnt_d = cnt_q - (LEN_W + 1)'(1);
                    if (cnt_q == (LEN_W + 1)'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stream outputs decoded from state; payload valid follows the FIFO directly
    always_comb begin
        st_valid = 1'b0;
        st_data  = '0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        st_empty = '0;
        case (state_q)
`ifdef PCAP_GLOBAL_HDR_EN
            StGhdr: begin
                st_valid = 1'b1;
                st_sop   = (gidx_q == 3'd0);
                case (gidx_q)
                    3'd0:    st_data = 32'hA1B2_C3D4;
                    3'd1:    st_data = 32'h0002_0004;
                    3'd4:    st_data = 32'h0000_FFFF;
                    3'd5:    st_data = 32'h0000_0001;
                    default: st_data = 32'h0000_0000;
                endcase
            end
`endif
            StHdr: begin
                st_valid = 1'b1;
`ifdef PCAP_GLOBAL_HDR_EN
                st_sop   = (hdr_idx_q == 2'd0) && !gh_rec_q;
`else
                st_sop   = (hdr_idx_q == 2'd0);
`endif
                st_eop   = (hdr_idx_q == 2'd3) && (cnt_q == '0);
                case (hdr_idx_q)
                    2'd0:    st_data = ts_sec_q;
                    2'd1:    st_data = 32'(ts_usec_q);
                    default: st_data = 32'(len_q);
                endcase
            end
            StPayload: begin
                st_valid = !fifo_empty;
                st_data  = fifo_rdata;
                if (cnt_q == (LEN_W + 1)'(1)) begin
                    st_eop   = 1'b1;
                    st_empty = 2'd0 - len_q[1:0];
                end
            end
            default: ;
        endcase
    end

    assign fifo_rdreq = (state_q == StPayload) && acc;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;

endmodule

// File: tb/tb_pcap_framer.sv
// Bench for pcap_framer: FIFO and sink models, a queue scoreboard of expected
// beats built from packet lengths and timestamp arithmetic, a vector table,
// randomized records and a few hand sequences.
module tb_pcap_framer;
    localparam int unsigned CLK_MHZ = 4;
    localparam int unsigned LEN_W   = 16;
    localparam int          BUDGET  = 2000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] pkt_len = '0;
    logic             busy, done, fifo_rdreq;
    logic [31:0]      fifo_rdata = 32'hDEAD_BEEF;
    logic             fifo_empty = 1'b1;
    logic [31:0]      st_data;
    logic             st_valid, st_sop, st_eop;
    logic             st_ready = 1'b1;
    logic [1:0]       st_empty;

    always #5 clk = ~clk;

    pcap_framer #(.CLK_MHZ(CLK_MHZ), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pkt_len    (pkt_len),
        .busy       (busy),
        .done       (done),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .st_data    (st_data),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_sop     (st_sop),
        .st_eop     (st_eop),
        .st_empty   (st_empty)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    typedef struct {
        int len;
        int beats;
        int last_empty;
    } vec_t;

    beat_t          exp_q[$];
    logic [31:0]    fq[$];
    int             n_tests = 0;
    int             n_fail = 0;
    longint unsigned cyc = 0;
    bit             m_busy = 0;
    bit             r_prev = 0;
    bit             s_eop_acc = 0;
    bit             s_rdreq = 0;
    bit             s_start = 0;
    bit             s_hold = 0;
    beat_t          s_beat = '0;
    bit             stall = 0;
    bit             gh_sent = 0;
    int             beat_cnt = 0;
    int             pop_cnt = 0;
    logic [1:0]     last_empty = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [31:0] d, input logic s, input logic e,
                                 input logic [1:0] em);
        beat_t b;
        b.data  = d;
        b.sop   = s;
        b.eop   = e;
        b.empty = em;
        return b;
    endfunction

    task automatic fifo_update();
        fifo_empty = stall || (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
    endtask

    // One clock: sample/check at negedge, update models at posedge, drive at posedge+1
    task automatic tick();
        beat_t got;
        beat_t e;
        bit    acc;
        bit    eop_now;
        @(negedge clk);
        got = {st_data, st_sop, st_eop, st_empty};
        acc = st_valid && st_ready;
        eop_now = 0;
        if (!r_prev) begin
            check("reset_outputs", {busy, done, fifo_rdreq, st_valid, st_sop, st_eop,
                                    st_empty, st_data}, 64'd0);
        end else begin
            check("busy", busy, m_busy);
            if (done || s_eop_acc) check("done", done, s_eop_acc);
            if (fifo_rdreq) check("rdreq_without_accept", acc, 1);
            if (s_hold && st_valid) check("hold_stable", got, s_beat);
            if (acc) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", got, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", got, e);
                    eop_now = e.eop;
                    beat_cnt++;
                    if (e.eop) last_empty = st_empty;
                end
            end
        end
        s_eop_acc = eop_now;
        s_rdreq   = fifo_rdreq;
        s_start   = start;
        s_hold    = st_valid && !st_ready;
        s_beat    = got;
        @(posedge clk);
        if (!reset) m_busy = 0;
        else if (s_eop_acc) m_busy = 0;
        else if (s_start && !m_busy) m_busy = 1;
        if (s_rdreq) begin
            if (fq.size() == 0) check("pop_on_empty", 1, 0);
            else begin
                void'(fq.pop_front());
                pop_cnt++;
            end
        end
        cyc = reset ? cyc + 1 : 0;
        r_prev = reset;
        #1;
        start = 1'b0;
        fifo_update();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        st_ready = 1'b1;
        stall = 0;
        fifo_update();
        for (int i = 0; i < n; i++) tick();
        exp_q.delete();
        fq.delete();
        gh_sent = 0;
        reset = 1'b1;
        fifo_update();
    endtask

    function automatic logic [31:0] gh_word(input int i);
        case (i)
            0:       return 32'hA1B2_C3D4;
            1:       return 32'h0002_0004;
            4:       return 32'h0000_FFFF;
            5:       return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Queue the expected record and the payload words, then pulse start
    task automatic start_record(input int len);
        int              nw;
        longint unsigned t;
        bit              sop_hdr;
        nw = (len + 3) / 4;
        t = cyc / CLK_MHZ;
        sop_hdr = 1;
`ifdef PCAP_GLOBAL_HDR_EN
        if (!gh_sent) begin
            for (int i = 0; i < 6; i++) exp_q.push_back(mk(gh_word(i), i == 0, 1'b0, 2'd0));
            sop_hdr = 0;
            gh_sent = 1;
        end
`endif
        exp_q.push_back(mk(32'(t / 64'd1000000), sop_hdr, 1'b0, 2'd0));
        exp_q.push_back(mk(32'(t % 64'd1000000), 1'b0, 1'b0, 2'd0));
        exp_q.push_back(mk(32'(len), 1'b0, 1'b0, 2'd0));
        exp_q.push_back(mk(32'(len), 1'b0, nw == 0, 2'd0));
        for (int i = 0; i < nw; i++) begin
            logic [31:0] w;
            w = $urandom;
            fq.push_back(w);
            exp_q.push_back(mk(w, 1'b0, i == nw - 1,
                               (i == nw - 1) ? 2'((4 - len % 4) % 4) : 2'd0));
        end
        pkt_len = LEN_W'(len);
        start = 1'b1;
        fifo_update();
    endtask

    // rmode: 0 ready=1, 1 random, 2 pattern 1,0,0,1; smode: 0 none, 1 random, 2 cycles 5..9
    task automatic run_until_idle(input int rmode, input int smode, input bit spur);
        int n;
        bit pat[4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        n = 0;
        tick();
        while ((m_busy || exp_q.size() != 0) && n < BUDGET) begin
            case (rmode)
                0:       st_ready = 1'b1;
                1:       st_ready = ($urandom_range(0, 1) == 1);
                default: st_ready = pat[n % 4];
            endcase
            case (smode)
                0:       stall = 0;
                1:       stall = ($urandom_range(0, 3) == 0);
                default: stall = (n >= 5 && n < 10);
            endcase
            if (spur && m_busy && $urandom_range(0, 7) == 0) begin
                pkt_len = LEN_W'($urandom);
                start = 1'b1;
            end
            fifo_update();
            tick();
            n++;
        end
        if (n >= BUDGET) check("record_timeout", n, 0);
        st_ready = 1'b1;
        stall = 0;
        fifo_update();
        tick();
        check("fifo_drained", fq.size(), 0);
    endtask

    initial begin
        vec_t        vecs[7];
        int          extra;
        logic [31:0] saved;
        int          n;

        vecs[0] = '{10, 7, 2};
        vecs[1] = '{0, 4, 0};
        vecs[2] = '{1, 5, 3};
        vecs[3] = '{4, 5, 0};
        vecs[4] = '{7, 6, 1};
        vecs[5] = '{8, 6, 0};
        vecs[6] = '{13, 8, 3};

        @(posedge clk);
        #1;
        do_reset(2);

        // Table of lengths with ready=1 and a preloaded FIFO
        foreach (vecs[i]) begin
            extra = 0;
`ifdef PCAP_GLOBAL_HDR_EN
            if (!gh_sent) extra = 6;
`endif
            beat_cnt = 0;
            start_record(vecs[i].len);
            run_until_idle(0, 0, 0);
            check("vec_beats", beat_cnt, vecs[i].beats + extra);
            check("vec_last_empty", last_empty, vecs[i].last_empty);
        end

        // Backpressure pattern with a 5-cycle FIFO gap, len=8
        pop_cnt = 0;
        start_record(8);
        run_until_idle(2, 2, 0);
        check("len8_pops", pop_cnt, 2);
        check("len8_empty", last_empty, 0);

        // Long idle gap so the header timestamp moves well past zero
        for (int i = 0; i < 3000; i++) tick();
        start_record(5);
        run_until_idle(0, 0, 0);

        // Randomized records with backpressure, FIFO gaps and spurious starts
        for (int r = 0; r < 40; r++) begin
            start_record($urandom_range(0, 40));
            run_until_idle(1, 1, 1);
            for (int i = 0; i < $urandom_range(0, 3); i++) tick();
        end

        // Reset mid-payload: abort with no EOP, leftover FIFO words untouched
        beat_cnt = 0;
        pop_cnt = 0;
        start_record(20);
        saved = fq[2];
        n = 0;
        tick();
        while (beat_cnt < ((exp_q.size() > 9) ? 12 : 6) && n < BUDGET) begin
            st_ready = 1'b1;
            tick();
            n++;
        end
        if (n >= BUDGET) check("reset_seq_timeout", n, 0);
        st_ready = 1'b0;
        reset = 1'b0;
        fifo_update();
        tick();
        reset = 1'b1;
        tick();
        check("reset_fifo_left", fq.size(), 3);
        check("reset_fifo_head", fq[0], saved);
        check("reset_pops", pop_cnt, 2);
        exp_q.delete();
        fq.delete();
        gh_sent = 0;
        st_ready = 1'b1;
        fifo_update();
        for (int i = 0; i < 3; i++) tick();

        // Records after the mid-record reset (global header reappears if enabled)
        for (int r = 0; r < 2; r++) begin
            extra = 0;
`ifdef PCAP_GLOBAL_HDR_EN
            if (!gh_sent) extra = 6;
`endif
            beat_cnt = 0;
            start_record(4);
            run_until_idle(0, 0, 0);
            check("len4_beats", beat_cnt, 5 + extra);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcap_framer.md
Name: pcap_framer

Overview:
Downstream consumer of the packet-read FIFO. The read controller fills that FIFO with 32-bit packet words.
- Per packet, this block emits a 16-byte pcap record header, then pops exactly ceil(pkt_len/4) payload words from the FIFO.
- Everything goes out on a 32-bit Avalon-ST source (SOP/EOP/empty) towards the dump sink (DMA/UART bridge).
- Also owns the free-running sec/usec timestamp used in record headers.

Parameters:
- CLK_MHZ, 50: clk frequency in MHz; number of clk cycles per microsecond tick.
- LEN_W, 16: width of pkt_len in bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latch pkt_len and timestamp, begin a record
- pkt_len  in  LEN_W  packet length in bytes (incl_len = orig_len)
- busy  out  1  high from accepted start until the EOP beat is accepted
- done  out  1  one-cycle pulse in the cycle after the EOP beat is accepted
- fifo_rdata  in  32  FIFO head word; show-ahead, valid when !fifo_empty
- fifo_empty  in  1  FIFO empty
- fifo_rdreq  out  1  pop FIFO head
- st_data  out  32  Avalon-ST data
- st_valid  out  1  Avalon-ST valid
- st_ready  in  1  Avalon-ST ready (readyLatency 0)
- st_sop  out  1  first beat of record
- st_eop  out  1  last beat of record
- st_empty  out  2  invalid bytes in the EOP beat

Behaviour:
- Reset (reset=0 at posedge):
  - state IDLE; busy, done, fifo_rdreq, st_valid, st_sop, st_eop = 0; st_empty = 0; st_data = 0.
  - Timestamp tick counter, usec and sec = 0.
- Timestamp:
  - tick counter counts 0..CLK_MHZ-1; on wrap, usec increments.
  - usec wraps 999999 -> 0 and increments sec (32-bit, wraps naturally).
  - Runs in every state.
- State machine: IDLE -> HDR -> PAYLOAD -> IDLE.
  - IDLE:
    - start=1: latch len = pkt_len, ts_sec/ts_usec = current sec/usec, words = ceil(len/4) = (len+3)>>2 computed in LEN_W+1 bits, hdr_idx = 0.
    - busy rises the following cycle; go to HDR.
  - HDR:
    - st_valid = 1; st_data per hdr_idx: 0 = ts_sec, 1 = ts_usec, 2 = zero-extended len, 3 = zero-extended len.
    - st_sop = (hdr_idx == 0).
    - hdr_idx advances only when st_valid & st_ready.
    - After beat 3 is accepted: if words == 0, the record ends; otherwise go to PAYLOAD with word counter = words.
    - len == 0: beat 3 carries st_eop = 1, st_empty = 0; return to IDLE.
  - PAYLOAD:
    - st_valid = !fifo_empty (combinational); st_data = fifo_rdata.
    - fifo_rdreq = st_valid & st_ready; the counter decrements on each pop.
    - The last word (counter == 1) has st_eop = 1 and st_empty = (4 - len[1:0]) & 3; all other beats have st_empty = 0.
    - After the last pop, go to IDLE; done pulses for 1 cycle; busy drops the same cycle.
- Avalon-ST rules:
  - st_data, st_sop, st_eop and st_empty stay stable while st_valid & !st_ready.
  - The FIFO head is never popped without acceptance.
  - st_valid in PAYLOAD may deassert when the FIFO runs empty; this is legal and the record resumes when data arrives.
- start while busy: ignored; no latch, no effect.
- start and the final accept in the same cycle: the start is ignored, because state is not yet IDLE.
- Reset mid-record:
  - Abort immediately to IDLE; no EOP is emitted.
  - FIFO contents are not flushed; flushing is the upstream owner's responsibility.
- Latency: first header beat is valid 1 cycle after start. Throughput is 1 beat/cycle with ready=1 and a non-empty FIFO.

Optional Feature:
- Macro PCAP_GLOBAL_HDR_EN.
- When defined: the first record after reset is preceded by a 6-beat pcap global header before its HDR beats:
  - beats: 0xA1B2C3D4, 0x00020004 (major 2, minor 4), 0x00000000, 0x00000000, 0x0000FFFF (snaplen), 0x00000001 (LINKTYPE_ETHERNET).
  - st_sop is on the first global beat; there is no st_sop on the record's first HDR beat.
  - A flag set on the last global beat suppresses the global header until the next reset.
- When undefined: no global header; the state and flag are not synthesized.

Test Plan:
- Timestamp: CLK_MHZ=4, run 4,000,010 cycles -> sec=1, usec=2; usec wrap 999999 -> 0 increments sec.
- start, pkt_len=10, FIFO preloaded with 3 words, st_ready=1 -> 7 beats: ts_sec, ts_usec, 10, 10, w0, w1, w2; sop on beat 0; eop on w2 with st_empty=2; done 1 cycle later; FIFO empty.
- pkt_len=0 -> 4 header beats, eop on beat 3 with st_empty=0; fifo_rdreq never asserted.
- pkt_len=8, st_ready toggling 1,0,0,1 and FIFO empty for 5 cycles mid-packet -> data held stable under backpressure; no pop without acceptance; exactly 2 pops; st_empty=0.
- Second start mid-record -> ignored. Reset asserted mid-payload -> IDLE next cycle, all outputs 0, remaining FIFO words untouched.
- PCAP_GLOBAL_HDR_EN defined, two records pkt_len=4 -> first stream 6+4+1 beats starting with 0xA1B2C3D4; second record 5 beats only.
